// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle for fifo_sync_param.
// The master is the producer/consumer side. The slave is the FIFO.
interface fifo_sync_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] din;
    logic             push;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output din, push, pop, clr_err,
        input  dout, empty, full, almost_empty, almost_full,
        input  count, overflow, underflow
    );

    modport slave (
        input  din, push, pop, clr_err,
        output dout, empty, full, almost_empty, almost_full,
        output count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock first-word-fall-through FIFO with any depth.
// It has occupancy thresholds and sticky overflow/underflow flags.
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input logic             clk,
    input logic             reset,
    fifo_sync_param_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             empty_w, full_w;
    logic             wr_acc, rd_acc;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));

    always_comb begin
        wr_acc   = bus.push && (!full_w || bus.pop);
        rd_acc   = bus.pop && !empty_w;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // An error event on the same edge as clr_err keeps the flag set
        ovf_d = (ovf_q && !bus.clr_err) || (bus.push && !bus.pop && full_w);
        udf_d = (udf_q && !bus.clr_err) || (bus.pop && empty_w);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage has no reset; the count masks stale entries
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.dout         = empty_w ? '0 : mem_q[rd_ptr_q];
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a directed 8x4 run and a randomised 2x3 run.
// Read data goes through a scoreboard queue; flags are checked against constants.
module tb_fifo_sync_param;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.WIDTH(8), .DEPTH(4)) if_a ();
    fifo_sync_param_if #(.WIDTH(2), .DEPTH(3)) if_b ();

    fifo_sync_param #(.WIDTH(8), .DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave)
    );
    fifo_sync_param #(.WIDTH(2), .DEPTH(3)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave)
    );

    logic [7:0] exp_a[$];
    logic [1:0] exp_b[$];
    int         mcnt_a = 0;
    int         mcnt_b = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare dout on each read the DUT accepts
    always @(negedge clk) begin
        if (reset && if_a.pop && !if_a.empty) begin
            if (exp_a.size() == 0) chk("a_unexpected_read", 32'(if_a.dout), 32'hdead);
            else chk("a_read_data", 32'(if_a.dout), 32'(exp_a.pop_front()));
        end
        if (reset && if_b.pop && !if_b.empty) begin
            if (exp_b.size() == 0) chk("b_unexpected_read", 32'(if_b.dout), 32'hdead);
            else chk("b_read_data", 32'(if_b.dout), 32'(exp_b.pop_front()));
        end
    end

    task automatic drive_a(input logic p, input logic [7:0] d,
                           input logic r, input logic c);
        logic wr, rd;
        if_a.push = p; if_a.din = d; if_a.pop = r; if_a.clr_err = c;
        wr = p && (mcnt_a < 4 || r);
        rd = r && (mcnt_a > 0);
        if (wr) exp_a.push_back(d);
        mcnt_a = mcnt_a + int'(wr) - int'(rd);
        @(posedge clk);
        #1;
        if_a.push = 1'b0; if_a.pop = 1'b0; if_a.clr_err = 1'b0;
    endtask

    task automatic drive_b(input logic p, input logic [1:0] d, input logic r);
        logic wr, rd;
        if_b.push = p; if_b.din = d; if_b.pop = r; if_b.clr_err = 1'b0;
        wr = p && (mcnt_b < 3 || r);
        rd = r && (mcnt_b > 0);
        if (wr) exp_b.push_back(d);
        mcnt_b = mcnt_b + int'(wr) - int'(rd);
        @(posedge clk);
        #1;
        if_b.push = 1'b0; if_b.pop = 1'b0;
        chk("b_count_model", 32'(if_b.count), 32'(mcnt_b));
        chk("b_count_le_depth", 32'(if_b.count <= 2'd3), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        if_a.push = 1'b0; if_a.pop = 1'b0; if_a.clr_err = 1'b0; if_a.din = '0;
        if_b.push = 1'b0; if_b.pop = 1'b0; if_b.clr_err = 1'b0; if_b.din = '0;
        #12;
        chk("rst_empty", 32'(if_a.empty), 32'd1);
        chk("rst_full", 32'(if_a.full), 32'd0);
        chk("rst_ae", 32'(if_a.almost_empty), 32'd1);
        chk("rst_af", 32'(if_a.almost_full), 32'd0);
        chk("rst_count", 32'(if_a.count), 32'd0);
        chk("rst_dout", 32'(if_a.dout), 32'd0);
        chk("rst_errs", 32'({if_a.overflow, if_a.underflow}), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        drive_a(1, 8'h11, 0, 0);
        chk("fwft_dout", 32'(if_a.dout), 32'h11);
        chk("one_empty", 32'(if_a.empty), 32'd0);
        chk("one_ae", 32'(if_a.almost_empty), 32'd1);
        drive_a(1, 8'h22, 0, 0);
        drive_a(1, 8'h33, 0, 0);
        chk("three_count", 32'(if_a.count), 32'd3);
        chk("three_af", 32'(if_a.almost_full), 32'd1);
        chk("three_full", 32'(if_a.full), 32'd0);
        chk("three_ae", 32'(if_a.almost_empty), 32'd0);
        drive_a(1, 8'h44, 0, 0);
        chk("four_count", 32'(if_a.count), 32'd4);
        chk("four_full", 32'(if_a.full), 32'd1);

        drive_a(1, 8'h55, 0, 0);
        chk("ovf_set", 32'(if_a.overflow), 32'd1);
        chk("ovf_count", 32'(if_a.count), 32'd4);
        chk("ovf_dout", 32'(if_a.dout), 32'h11);
        repeat (4) drive_a(0, 8'h00, 1, 0);
        chk("drain_empty", 32'(if_a.empty), 32'd1);
        chk("drain_dout", 32'(if_a.dout), 32'd0);
        drive_a(0, 8'h00, 0, 1);
        chk("ovf_clr", 32'(if_a.overflow), 32'd0);

        drive_a(1, 8'h11, 0, 0);
        drive_a(1, 8'h22, 0, 0);
        drive_a(1, 8'h33, 0, 0);
        drive_a(1, 8'h44, 0, 0);
        drive_a(1, 8'h66, 1, 0);
        chk("pp_full_count", 32'(if_a.count), 32'd4);
        chk("pp_full_full", 32'(if_a.full), 32'd1);
        chk("pp_full_ovf", 32'(if_a.overflow), 32'd0);
        chk("pp_full_dout", 32'(if_a.dout), 32'h22);
        repeat (4) drive_a(0, 8'h00, 1, 0);
        chk("wrap_empty", 32'(if_a.empty), 32'd1);

        drive_a(0, 8'h00, 1, 0);
        chk("udf_set", 32'(if_a.underflow), 32'd1);
        chk("udf_count", 32'(if_a.count), 32'd0);
        drive_a(0, 8'h00, 0, 1);
        chk("udf_clr", 32'(if_a.underflow), 32'd0);
        drive_a(0, 8'h00, 1, 1);
        chk("udf_wins_clr", 32'(if_a.underflow), 32'd1);
        drive_a(0, 8'h00, 0, 1);
        drive_a(1, 8'h77, 1, 0);
        chk("pp_empty_count", 32'(if_a.count), 32'd1);
        chk("pp_empty_dout", 32'(if_a.dout), 32'h77);
        chk("pp_empty_udf", 32'(if_a.underflow), 32'd1);

        drive_a(1, 8'h88, 0, 0);
        drive_a(1, 8'h99, 0, 0);
        chk("pre_rst_count", 32'(if_a.count), 32'd3);
        #2 reset = 1'b0;
        #1;
        chk("arst_empty", 32'(if_a.empty), 32'd1);
        chk("arst_count", 32'(if_a.count), 32'd0);
        chk("arst_dout", 32'(if_a.dout), 32'd0);
        exp_a.delete();
        mcnt_a = 0;
        reset = 1'b1;
        drive_a(1, 8'hA5, 0, 0);
        chk("post_rst_dout", 32'(if_a.dout), 32'hA5);
        chk("post_rst_count", 32'(if_a.count), 32'd1);
        drive_a(0, 8'h00, 1, 0);
        chk("a_queue_left", 32'(exp_a.size()), 32'd0);

        for (int i = 0; i < 30; i++) begin
            drive_b(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end
        while (mcnt_b > 0) drive_b(0, 2'd0, 1);
        chk("b_empty_end", 32'(if_b.empty), 32'd1);
        chk("b_queue_left", 32'(exp_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
